tiny_prog_loader: RTL and testbench

TINY_PROG_LOADER -- requirements
Module: tiny_prog_loader

---
 rtl/tiny_prog_loader.sv | 206 ++++++++++++++++++++
 tb/tb_tiny_prog_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tiny_prog_loader.sv
// Program loader: streams 16 bytes into a 16x8 program memory while holding the CPU in reset.
// Optional trailing checksum byte when TINY_PROG_LOADER_CHECKSUM_EN is defined.
module tiny_prog_loader #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_p,
  input  logic       load_start,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic [3:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       cpu_reset_p,
  output logic       load_err,
  output logic [4:0] byte_count
);

`ifdef TINY_PROG_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_LOAD = 2'd1, ST_ERROR = 2'd2, ST_CHECK = 2'd3} state_e;
  localparam state_e ST_LOAD_DONE = ST_CHECK;
`else
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_LOAD = 2'd1, ST_ERROR = 2'd2} state_e;
  localparam state_e ST_LOAD_DONE = ST_RUN;
`endif

  localparam int            TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  function automatic logic [7:0] default_image(input logic [3:0] addr);
    case (addr)
      4'd0:    default_image = 8'h81;
      4'd1:    default_image = 8'h82;
      4'd2:    default_image = 8'h84;
      4'd3:    default_image = 8'h88;
      4'd4:    default_image = 8'h84;
      4'd5:    default_image = 8'h82;
      4'd6:    default_image = 8'hA0;
      default: default_image = 8'h00;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [4:0]    byte_count_q, byte_count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          s_ready_q, s_ready_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          load_err_q, load_err_d;
  logic [7:0]    mem_q [16];
  logic          load_go_s, xfer_s, wr_en_s, timeout_s;

  // Outputs are registered from the current state, so they trail a transition by one cycle;
  // transfers are therefore also qualified by the state itself.
  assign load_go_s = load_start & ((state_q == ST_RUN) | (state_q == ST_ERROR));
  assign wr_en_s   = s_valid & s_ready_q & (state_q == ST_LOAD);
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
  assign xfer_s    = s_valid & s_ready_q & ((state_q == ST_LOAD) | (state_q == ST_CHECK));
`else
  assign xfer_s    = wr_en_s;
`endif
  assign timeout_s = TIMEOUT_EN & (timer_q == TIMER_LAST);

`ifdef TINY_PROG_LOADER_CHECKSUM_EN
  logic [7:0] acc_q;
  logic       ck_ok_s;

  // Running modulo-256 sum of accepted program bytes
  always_ff @(posedge clock) begin
    if (reset_p) begin
      acc_q <= 8'd0;
    end else if (load_go_s) begin
      acc_q <= 8'd0;
    end else if (wr_en_s) begin
      acc_q <= acc_q + s_data;
    end
  end

  assign ck_ok_s = (s_data == acc_q);
`endif

  // State, counter, timer and registered output flops
  always_ff @(posedge clock) begin
    if (reset_p) begin
      state_q      <= ST_RUN;
      byte_count_q <= 5'd0;
      timer_q      <= {TW{1'b0}};
      s_ready_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      timer_q      <= timer_d;
      s_ready_q    <= s_ready_d;
      cpu_reset_q  <= cpu_reset_d;
      load_err_q   <= load_err_d;
    end
  end

  // Program memory: reset restores the default image and wins over a same-cycle write
  always_ff @(posedge clock) begin
    if (reset_p) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= default_image(4'(i));
      end
    end else if (wr_en_s) begin
      mem_q[byte_count_q[3:0]] <= s_data;
    end
  end

  // Next-state, byte counter and idle timer
  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    timer_d      = timer_q;
    case (state_q)
      ST_RUN, ST_ERROR: begin
        if (load_go_s) begin
          state_d      = ST_LOAD;
          byte_count_d = 5'd0;
          timer_d      = {TW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          byte_count_d = byte_count_q + 5'd1;
          timer_d      = {TW{1'b0}};
          if (byte_count_q == 5'd15) begin
            state_d = ST_LOAD_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          timer_d = timer_q + TW'(1'b1);
          if (timeout_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer_s) begin
          timer_d = {TW{1'b0}};
          if (ck_ok_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          timer_d = timer_q + TW'(1'b1);
          if (timeout_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  // Output values decoded from the current state, captured one cycle later
  always_comb begin
    s_ready_d   = 1'b0;
    cpu_reset_d = 1'b1;
    load_err_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        s_ready_d   = 1'b0;
        cpu_reset_d = 1'b0;
      end
      ST_LOAD: begin
        s_ready_d   = 1'b1;
        cpu_reset_d = 1'b1;
      end
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        s_ready_d   = 1'b1;
        cpu_reset_d = 1'b1;
      end
`endif
      ST_ERROR: begin
        s_ready_d   = 1'b0;
        cpu_reset_d = 1'b1;
        load_err_d  = 1'b1;
      end
      default: begin
        s_ready_d   = 1'b0;
        cpu_reset_d = 1'b1;
      end
    endcase
  end

  assign s_ready     = s_ready_q;
  assign cpu_reset_p = cpu_reset_q;
  assign load_err    = load_err_q;
  assign byte_count  = byte_count_q;
  assign fetch_data  = mem_q[fetch_addr];

endmodule

// File: tb/tb_tiny_prog_loader.sv
// Self-checking bench for tiny_prog_loader: image table, directed corner sequences and a
// randomized run compared every cycle against a transaction-level model.
module tb_tiny_prog_loader;
  localparam int TO = 8;
`ifdef TINY_PROG_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       clock;
  logic       reset_p, load_start, s_valid, s_ready, cpu_reset_p, load_err;
  logic [7:0] s_data, fetch_data;
  logic [3:0] fetch_addr;
  logic [4:0] byte_count;

  tiny_prog_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_p(reset_p), .load_start(load_start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .cpu_reset_p(cpu_reset_p), .load_err(load_err), .byte_count(byte_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } img_vec_t;
  img_vec_t img_tbl [16];

  int n_err = 0;
  int n_chk = 0;

  // Model: mode 0=running, 1=loading, 2=awaiting checksum, 3=failed
  int         m_mode, m_cnt, m_sum, m_idle;
  logic [7:0] m_mem [16];
  bit         e_ready, e_cpurst, e_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_tick();
    if (m_idle == TO - 1) m_mode = 3;
    else m_idle++;
  endtask

  task automatic model_step();
    int prev;
    bit acc;
    if (reset_p) begin
      for (int i = 0; i < 16; i++) m_mem[i] = img_tbl[i].data;
      m_mode = 0; m_cnt = 0; m_sum = 0; m_idle = 0;
      e_ready = 1'b0; e_cpurst = 1'b1; e_err = 1'b0;
    end else begin
      prev = m_mode;
      acc  = s_valid && e_ready && (m_mode == 1 || m_mode == 2);
      case (m_mode)
        0, 3: if (load_start) begin
          m_mode = 1; m_cnt = 0; m_sum = 0; m_idle = 0;
        end
        1: if (acc) begin
          m_mem[m_cnt] = s_data;
          m_cnt++;
          m_sum  = (m_sum + int'(s_data)) % 256;
          m_idle = 0;
          if (m_cnt == 16) m_mode = CK_EN ? 2 : 0;
        end else idle_tick();
        2: if (acc) begin
          m_idle = 0;
          m_mode = (int'(s_data) == m_sum) ? 0 : 3;
        end else idle_tick();
        default: m_mode = 0;
      endcase
      e_ready  = (prev == 1 || prev == 2);
      e_cpurst = (prev != 0);
      e_err    = (prev == 3);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    chk("s_ready",     32'(s_ready),     32'(e_ready));
    chk("cpu_reset_p", 32'(cpu_reset_p), 32'(e_cpurst));
    chk("load_err",    32'(load_err),    32'(e_err));
    chk("byte_count",  32'(byte_count),  32'(m_cnt));
    chk("fetch_data",  32'(fetch_data),  32'(m_mem[fetch_addr]));
  endtask

  task automatic do_load(input logic [7:0] ck);
    load_start = 1'b1; cycle();
    load_start = 1'b0; cycle();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'h10 + 8'(i); cycle();
    end
    if (CK_EN) begin
      s_data = ck; cycle();
    end
    s_valid = 1'b0; cycle(); cycle();
  endtask

  initial begin
    img_tbl = '{'{4'd0, 8'h81}, '{4'd1, 8'h82}, '{4'd2, 8'h84}, '{4'd3, 8'h88},
                '{4'd4, 8'h84}, '{4'd5, 8'h82}, '{4'd6, 8'hA0}, '{4'd7, 8'h00},
                '{4'd8, 8'h00}, '{4'd9, 8'h00}, '{4'd10, 8'h00}, '{4'd11, 8'h00},
                '{4'd12, 8'h00}, '{4'd13, 8'h00}, '{4'd14, 8'h00}, '{4'd15, 8'h00}};
    reset_p = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = 8'h00; fetch_addr = 4'd0;
    cycle(); cycle();

    // Reset state and release
    chk("rst_cpu_reset", 32'(cpu_reset_p), 32'd1);
    chk("rst_s_ready",   32'(s_ready),     32'd0);
    fetch_addr = 4'd6; #1;
    chk("rst_fetch6",    32'(fetch_data),  32'hA0);
    reset_p = 1'b0; cycle();
    chk("rel_cpu_reset", 32'(cpu_reset_p), 32'd0);

    // Default image table
    for (int i = 0; i < 16; i++) begin
      fetch_addr = img_tbl[i].addr; cycle();
      chk($sformatf("img%0d", i), 32'(fetch_data), 32'(img_tbl[i].data));
    end

    // Timeout after 3 bytes
    load_start = 1'b1; cycle();
    load_start = 1'b0; cycle();
    s_valid = 1'b1; s_data = 8'h5A; cycle();
    s_data = 8'hC3; cycle();
    s_data = 8'h3C; cycle();
    s_valid = 1'b0;
    repeat (8) cycle();
    chk("to_err_not_yet", 32'(load_err), 32'd0);
    cycle();
    chk("to_err",        32'(load_err),    32'd1);
    chk("to_cpu_reset",  32'(cpu_reset_p), 32'd1);
    chk("to_count",      32'(byte_count),  32'd3);
    fetch_addr = 4'd3; cycle();
    chk("to_mem3",       32'(fetch_data),  32'h88);
    fetch_addr = 4'd0; cycle();
    chk("to_mem0",       32'(fetch_data),  32'h5A);

    // Reload from error, same-cycle write/fetch, ignored mid-load start
    load_start = 1'b1; cycle();
    load_start = 1'b0; cycle();
    s_valid = 1'b1; s_data = 8'h11; cycle();
    s_data = 8'h22; load_start = 1'b1; cycle();
    load_start = 1'b0;
    chk("mid_start_count", 32'(byte_count), 32'd2);
    fetch_addr = 4'd2; s_data = 8'h33; #1;
    chk("wr_fetch_old",  32'(fetch_data),  32'h3C);
    cycle();
    chk("wr_fetch_new",  32'(fetch_data),  32'h33);
    chk("wr_count",      32'(byte_count),  32'd3);
    s_data = 8'h44; cycle();
    s_data = 8'h55; cycle();
    chk("pre_rst_count", 32'(byte_count),  32'd5);

    // Reset mid-load with a byte offered in the same cycle
    reset_p = 1'b1; s_data = 8'hFF; cycle();
    reset_p = 1'b0; s_valid = 1'b0; cycle();
    chk("midrst_count",  32'(byte_count),  32'd0);
    for (int i = 0; i < 16; i++) begin
      fetch_addr = img_tbl[i].addr; cycle();
      chk($sformatf("restored%0d", i), 32'(fetch_data), 32'(img_tbl[i].data));
    end

    // Full good load
    do_load(8'h78);
    chk("load_count",    32'(byte_count),  32'd16);
    chk("load_cpu_rst",  32'(cpu_reset_p), 32'd0);
    chk("load_err_ok",   32'(load_err),    32'd0);
    fetch_addr = 4'd15; cycle();
    chk("load_mem15",    32'(fetch_data),  32'h1F);
    chk("load_hold16",   32'(byte_count),  32'd16);

    if (CK_EN) begin
      do_load(8'h77);
      chk("bad_ck_err",  32'(load_err),    32'd1);
      chk("bad_ck_cpu",  32'(cpu_reset_p), 32'd1);
      load_start = 1'b1; cycle();
      load_start = 1'b0; cycle();
      chk("bad_ck_clear", 32'(load_err),   32'd0);
    end

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      reset_p    = ($urandom_range(0, 499) == 0);
      load_start = ($urandom_range(0, 39) == 0);
      if ((c / 150) % 2 == 0) s_valid = ($urandom_range(0, 3) != 0);
      else                    s_valid = ($urandom_range(0, 7) == 0);
      if (m_mode == 2 && $urandom_range(0, 1) == 1) s_data = 8'(m_sum);
      else                                          s_data = 8'($urandom);
      fetch_addr = 4'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
